// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : prog_loader
//  Purpose  : Byte-stream loader that fills picoMIPS program memory and holds
//             the CPU in reset until a complete image has been written.
//  Revision : 1.0  initial release
// ============================================================================
module prog_loader #(
    parameter int Psize = 6,
    parameter int Isize = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic             pm_we,
    output logic [Psize-1:0] pm_addr,
    output logic [Isize-1:0] pm_wdata,
    output logic             cpu_hold,
    output logic             done,
    output logic             error
);

    localparam int c_BPW = Isize / 8;
    localparam int c_CW  = (c_BPW > 1) ? $clog2(c_BPW) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t           r_state;
    logic [Psize:0]   r_words_left;
    logic [c_CW-1:0]  r_byte_cnt;

    logic w_xfer;
    logic w_hdr_bad;
    logic w_last_byte;
    logic w_last_word;

    assign w_xfer      = byte_valid && byte_ready;
    // Header bits above the address width must be zero when Psize < 8.
    assign w_hdr_bad   = (Psize < 8) && ((byte_in >> Psize) != 8'd0);
    assign w_last_byte = (r_byte_cnt == c_CW'(c_BPW - 1));
    assign w_last_word = (r_words_left == (Psize+1)'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_words_left <= '0;
            r_byte_cnt   <= '0;
            byte_ready   <= 1'b0;
            pm_we        <= 1'b0;
            pm_addr      <= '0;
            pm_wdata     <= '0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        r_state    <= S_HDR;
                        byte_ready <= 1'b1;
                        cpu_hold   <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        r_byte_cnt <= '0;
                    end
                end
                S_HDR: begin
                    if (abort) begin
                        r_state    <= S_ERR;
                        byte_ready <= 1'b0;
                        error      <= 1'b1;
                        cpu_hold   <= 1'b1;
                    end else if (w_xfer) begin
                        if (w_hdr_bad) begin
                            r_state    <= S_ERR;
                            byte_ready <= 1'b0;
                            error      <= 1'b1;
                            cpu_hold   <= 1'b1;
                        end else begin
                            r_state      <= S_DATA;
                            r_words_left <= {1'b0, byte_in[Psize-1:0]} + (Psize+1)'(1);
                            pm_addr      <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (abort) begin
                        r_state    <= S_ERR;
                        byte_ready <= 1'b0;
                        error      <= 1'b1;
                        cpu_hold   <= 1'b1;
                    end else if (w_xfer) begin
                        pm_wdata <= Isize'({pm_wdata, byte_in});
                        if (w_last_byte) begin
                            r_state    <= S_WRITE;
                            r_byte_cnt <= '0;
                            byte_ready <= 1'b0;
                            pm_we      <= 1'b1;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + c_CW'(1);
                        end
                    end
                end
                S_WRITE: begin
                    pm_we <= 1'b0;
                    if (w_last_word) begin
                        r_state  <= S_DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        r_state      <= S_DATA;
                        byte_ready   <= 1'b1;
                        pm_addr      <= pm_addr + Psize'(1);
                        r_words_left <= r_words_left - (Psize+1)'(1);
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    byte_ready <= 1'b0;
                    pm_we      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prog_loader
//  Purpose  : Directed and randomized checks of prog_loader against a simple
//             image-to-write-list reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prog_loader;

    localparam int P = 6;
    localparam int I = 24;

    logic         clk;
    logic         reset;
    logic         start;
    logic         abort;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         byte_ready;
    logic         pm_we;
    logic [P-1:0] pm_addr;
    logic [I-1:0] pm_wdata;
    logic         cpu_hold;
    logic         done;
    logic         error;

    int n_checks = 0;
    int n_fail   = 0;

    logic [P+I-1:0] wq[$];     // observed writes {addr,data}
    logic [P+I-1:0] eq[$];     // expected writes from the model

    prog_loader #(.Psize(P), .Isize(I)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (pm_we) wq.push_back({pm_addr, pm_wdata});

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents one byte after 'gap' idle cycles; returns on the negedge after acceptance.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit acc;
        int t;
        acc = 1'b0;
        t   = 0;
        for (int g = 0; g < gap; g++) @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        while (!acc && t < 50) begin
            acc = byte_ready;
            @(negedge clk);
            t++;
        end
        byte_valid = 1'b0;
        if (!acc) chk("byte_accept_timeout", 0, 1);
    endtask

    task automatic wait_end();
        int t;
        t = 0;
        while (!done && !error && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!done && !error) chk("end_timeout", 0, 1);
    endtask

    // Builds the expected write list for an image and streams it with random gaps.
    task automatic load_image(input int nwords, input int maxgap);
        logic [I-1:0] w;
        eq.delete();
        wq.delete();
        pulse_start();
        send_byte(8'(nwords - 1), $urandom_range(0, maxgap));
        for (int k = 0; k < nwords; k++) begin
            w = I'($urandom);
            eq.push_back({P'(k), w});
            for (int j = I/8 - 1; j >= 0; j--)
                send_byte(w[j*8 +: 8], $urandom_range(0, maxgap));
        end
        wait_end();
    endtask

    initial begin
        logic [7:0] img[7];
        logic [7:0] b0, b1, b2, c0, c1;
        reset = 1'b1; start = 1'b0; abort = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;

        // Reset values
        #2;
        chk("rst_byte_ready", byte_ready, 0);
        chk("rst_pm_we",      pm_we,      0);
        chk("rst_pm_addr",    pm_addr,    0);
        chk("rst_cpu_hold",   cpu_hold,   1);
        chk("rst_done",       done,       0);
        chk("rst_error",      error,      0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_byte_ready", byte_ready, 0);
        chk("idle_cpu_hold",   cpu_hold,   1);

        // Two-word directed load with byte_valid held high
        img = '{8'h01, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
        wq.delete();
        pulse_start();
        chk("hdr_byte_ready", byte_ready, 1);
        for (int i = 0; i < 7; i++) begin
            send_byte(img[i], 0);
            if (i == 3) begin
                chk("w0_we",   pm_we,    1);
                chk("w0_addr", pm_addr,  0);
                chk("w0_data", pm_wdata, 24'h123456);
                chk("w0_rdy",  byte_ready, 0);
            end else if (i == 6) begin
                chk("w1_we",   pm_we,    1);
                chk("w1_addr", pm_addr,  1);
                chk("w1_data", pm_wdata, 24'hABCDEF);
            end else begin
                chk("no_we_mid_word", pm_we, 0);
            end
        end
        wait_end();
        chk("two_done",     done,      1);
        chk("two_cpu_hold", cpu_hold,  0);
        chk("two_nwrites",  wq.size(), 2);

        // Full 64-word image with random gaps
        load_image(64, 3);
        chk("full_done",    done,      1);
        chk("full_nwrites", wq.size(), 64);
        for (int k = 0; k < 64 && k < wq.size(); k++)
            chk($sformatf("full_w%0d", k), wq[k], eq[k]);

        // Out-of-range header, then a one-word recovery load
        wq.delete();
        pulse_start();
        send_byte(8'h40, 0);
        chk("bad_hdr_error",    error,      1);
        chk("bad_hdr_rdy",      byte_ready, 0);
        chk("bad_hdr_cpu_hold", cpu_hold,   1);
        chk("bad_hdr_done",     done,       0);
        repeat (3) @(negedge clk);
        chk("bad_hdr_nwrites",  wq.size(),  0);
        pulse_start();
        chk("restart_clr_err", error, 0);
        send_byte(8'h00, 0);
        for (int j = 0; j < 3; j++) send_byte(8'hFF, 1);
        wait_end();
        chk("one_done",   done,  1);
        chk("one_error",  error, 0);
        chk("one_nwrite", wq.size(), 1);
        if (wq.size() > 0) chk("one_w0", wq[0], {6'd0, 24'hFFFFFF});

        // start ignored in DATA, abort mid-word
        wq.delete();
        b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
        c0 = 8'($urandom); c1 = 8'($urandom);
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(b0, 1); send_byte(b1, 0); send_byte(b2, 2);
        send_byte(c0, 0); send_byte(c1, 1);
        pulse_start();
        chk("start_in_data_rdy",  byte_ready, 1);
        chk("start_in_data_addr", pm_addr,    1);
        chk("start_in_data_done", done,       0);
        abort = 1'b1; byte_in = 8'h5A; byte_valid = 1'b1;
        @(negedge clk);
        abort = 1'b0; byte_valid = 1'b0;
        chk("abort_error", error,      1);
        chk("abort_rdy",   byte_ready, 0);
        chk("abort_hold",  cpu_hold,   1);
        chk("abort_wdata", pm_wdata,   {b2, c0, c1});
        repeat (3) @(negedge clk);
        chk("abort_nwrites", wq.size(), 1);

        // Asynchronous reset during WRITE
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
        chk("pre_rst_we", pm_we, 1);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_we",   pm_we,      0);
        chk("async_rst_hold", cpu_hold,   1);
        chk("async_rst_rdy",  byte_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_idle_rdy",  byte_ready, 0);
        chk("post_rst_idle_done", done,       0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream loader that writes a program image into picoMIPS program memory; it is the write side of the instruction memory the program counter reads.
- Holds the CPU (PC and core) in reset while loading, then releases it so execution starts from address 0.
- Sits between a host byte source (UART/JTAG bridge) and the program memory write port.

Parameters:
- Psize, 6, program memory address width; memory depth 2^Psize words.
- Isize, 24, instruction width in bits; must be a multiple of 8. BPW = Isize/8 bytes per word.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a load from IDLE, DONE or ERR.
- abort  input  1  level; forces ERR when sampled high in HDR or DATA.
- byte_in  input  8  stream data byte.
- byte_valid  input  1  byte_in valid.
- byte_ready  output  1  loader can accept a byte; transfer occurs when byte_valid && byte_ready at a rising edge.
- pm_we  output  1  program memory write enable, one-cycle pulse per word.
- pm_addr  output  Psize  program memory write address.
- pm_wdata  output  Isize  program memory write data.
- cpu_hold  output  1  high holds the CPU/PC in reset.
- done  output  1  level; last load completed successfully.
- error  output  1  level; last load failed.

Behaviour:
- All outputs are registered. On reset, asynchronously: state=IDLE, byte_ready=0, pm_we=0, pm_addr=0, pm_wdata=0, cpu_hold=1, done=0, error=0, internal counters=0.
- IDLE:
  - byte_ready=0.
  - start -> HDR, with cpu_hold=1, done=0, error=0, byte count=0.
- HDR:
  - byte_ready=1.
  - On a transfer, if byte_in[7:Psize] != 0 (only checked when Psize<8) -> ERR.
  - Otherwise words_left = byte_in[Psize-1:0] + 1 (Psize+1 bits, range 1..2^Psize), pm_addr=0 -> DATA.
- DATA:
  - byte_ready=1.
  - Each transfer shifts MSB-first: pm_wdata = {pm_wdata[Isize-9:0], byte_in}; byte count increments.
  - On the BPW-th byte -> WRITE and byte count clears.
  - Gaps in byte_valid are allowed with no timeout.
- WRITE:
  - byte_ready=0, pm_we=1 for exactly this cycle; pm_addr and pm_wdata stable.
  - If words_left==1 -> DONE.
  - Otherwise pm_addr += 1, words_left -= 1 -> DATA.
- Latency: the last byte of a word accepted on edge t gives pm_we high from edge t to edge t+1. Every word costs BPW+1 cycles minimum.
- DONE: done=1, cpu_hold=0, byte_ready=0. start -> HDR.
- ERR: error=1, cpu_hold=1, byte_ready=0, pm_we=0. start -> HDR.
- abort high in HDR or DATA -> ERR on the next edge; the byte presented in that cycle is not accepted. abort is ignored in IDLE, WRITE, DONE and ERR.
- start is ignored in HDR, DATA and WRITE.
- pm_addr never wraps during a load; the maximum header value 2^Psize-1 ends with a write at address 2^Psize-1.
- Reset mid-load: immediate return to IDLE with pm_we=0 and cpu_hold=1; partially written memory contents are left as-is.

Test Plan:
- Assert reset -> byte_ready=0, pm_we=0, pm_addr=0, cpu_hold=1, done=0, error=0; after deassertion state stays IDLE with no start.
- start, then bytes 0x01,0x12,0x34,0x56,0xAB,0xCD,0xEF with byte_valid held high -> two pm_we pulses: addr 0 data 0x123456, addr 1 data 0xABCDEF; pm_we asserted one cycle after each third byte; then done=1, cpu_hold=0.
- Header 0x3F followed by 64 words with random byte_valid gaps -> 64 pm_we pulses at addresses 0..63 in order with matching data; no pulse at a wrapped address 0; done=1.
- Header 0x40 -> error=1, no pm_we, byte_ready=0, cpu_hold=1; a following start with header 0x00 and word 0xFFFFFF -> one write at addr 0, done=1, error=0.
- abort raised after 2 bytes of word 1, and a start pulse injected during DATA -> start has no effect; abort gives ERR next cycle with no further pm_we and byte_ready=0.
- Asynchronous reset asserted in WRITE (pm_we=1) -> pm_we drops with no clock edge, cpu_hold=1, state IDLE.
